// File: rtl/adder_4b.sv
// 4-bit ripple-carry adder with carry-in; sum, carry-out and signed overflow
// are registered, so results appear one clock after the operands.

module adder_4b_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] S,
    output logic             C4,
    output logic             V
);
    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] s_d, s_q;
    logic             c4_d, c4_q;
    logic             v_d, v_q;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        adder_4b_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_comb begin
        s_d  = sum;
        c4_d = carry[WIDTH];
        // Signed overflow: carry into the sign bit disagrees with carry out of it.
        v_d  = carry[WIDTH-1] ^ carry[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= '0;
            c4_q <= 1'b0;
            v_q  <= 1'b0;
        end else begin
            s_q  <= s_d;
            c4_q <= c4_d;
            v_q  <= v_d;
        end
    end

    assign S  = s_q;
    assign C4 = c4_q;
    assign V  = v_q;
endmodule

// File: tb/tb_adder_4b.sv
// Bench for adder_4b: directed boundary cases, exhaustive sweep and random
// operands, all checked against an integer-arithmetic reference model.

module tb_adder_4b;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       c_in = 1'b0;
    logic [3:0] S;
    logic       C4;
    logic       V;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];   // {v, c4, s[3:0]}

    adder_4b dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .c_in (c_in),
        .S    (S),
        .C4   (C4),
        .V    (V)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer addition.
    function automatic logic [5:0] ref_model(input logic [3:0] ra, input logic [3:0] rb,
                                             input logic rc);
        int u, sa, sb, ss;
        logic [4:0] u5;
        logic ov;
        u  = int'(ra) + int'(rb) + int'(rc);
        u5 = u[4:0];
        sa = ra[3] ? int'(ra) - 16 : int'(ra);
        sb = rb[3] ? int'(rb) - 16 : int'(rb);
        ss = sa + sb + int'(rc);
        ov = (ss > 7) || (ss < -8);
        return {ov, u5};
    endfunction

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {V, C4, S};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed V=%b C4=%b S=%b, expected V=%b C4=%b S=%b",
                   tag, obs[5], obs[4], obs[3:0], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Apply operands, clock once, then compare with the queued expectation.
    task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc);
        a = ta; b = tb; c_in = tc;
        exp_q.push_back(ref_model(ta, tb, tc));
        @(posedge clk);
        #1;
        check(tag, exp_q.pop_front());
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic       rc;

        // Reset: load a non-zero result first, then assert rst with no clock edge.
        a = 4'b1111; b = 4'b1111; c_in = 1'b1;
        @(posedge clk); #1;
        check("preload", 6'b0_1_1111);
        rst = 1'b1;
        #1;
        check("async_reset", 6'b0_0_0000);
        @(posedge clk); #1;
        check("reset_held", 6'b0_0_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_after_reset", 6'b0_1_1111);

        step("zero",         4'b0000, 4'b0000, 1'b0);
        step("cin_wrap_ab",  4'b1111, 4'b0000, 1'b1);
        step("cin_wrap_ba",  4'b0000, 4'b1111, 1'b1);
        step("op_wrap_ab",   4'b1111, 4'b0001, 1'b0);
        step("op_wrap_ba",   4'b0001, 4'b1111, 1'b0);
        step("ovf_pos",      4'b0111, 4'b0001, 1'b0);
        step("ovf_neg",      4'b1000, 4'b1000, 1'b0);
        step("max_all",      4'b1111, 4'b1111, 1'b1);
        step("ovf_cin",      4'b0111, 4'b0000, 1'b1);

        // Exhaustive sweep, one combination per cycle.
        for (int i = 0; i < 512; i++) begin
            step("sweep", i[7:4], i[3:0], i[8]);
        end

        // Random operands, each also checked with operands swapped.
        for (int i = 0; i < 100; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            step("rand", ra, rb, rc);
            step("rand_swap", rb, ra, rc);
        end

        // Mid-stream reset clears the outputs immediately.
        a = 4'b1010; b = 4'b0111; c_in = 1'b1;
        @(posedge clk); #1;
        check("pre_midreset", ref_model(4'b1010, 4'b0111, 1'b1));
        rst = 1'b1;
        #1;
        check("mid_reset", 6'b0_0_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_midreset", ref_model(4'b1010, 4'b0111, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
